// File: rtl/mcycle_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory, writeback.
// Sticky fault flags; absorbing FAULT state with memory-wait timeout.
module mcycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pc_src,
  output logic        reg_wr_en,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    C_ALU    = 2'd0,
    C_LOAD   = 2'd1,
    C_STORE  = 2'd2,
    C_BRANCH = 2'd3
  } cls_e;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] retire_q, retire_d;
  logic        ill_q, ill_d;
  logic        berr_q, berr_d;

  cls_e        op_cls;
  logic        op_legal;

  always_comb begin
    op_cls   = C_ALU;
    op_legal = 1'b1;
    case (opcode)
      7'b0110011,
      7'b0010011,
      7'b0110111,
      7'b0010111: op_cls = C_ALU;
      7'b0000011: op_cls = C_LOAD;
      7'b0100011: op_cls = C_STORE;
      7'b1100011: op_cls = C_BRANCH;
      default:    op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wait_d    = '0;
    retire_d  = retire_q;
    ill_d     = ill_q;
    berr_d    = berr_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    pc_src    = 1'b0;
    reg_wr_en = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == TMO_LAST) begin
          state_d = S_FAULT;
          berr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          cls_d   = op_cls;
          state_d = S_EXEC;
        end else begin
          ill_d   = 1'b1;
          state_d = S_FAULT;
        end
      end
      S_EXEC: begin
        unique case (cls_q)
          C_ALU:   state_d = S_WB;
          C_LOAD,
          C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            pc_en    = 1'b1;
            pc_src   = branch_taken;
            retire_d = retire_q + 32'd1;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ready) begin
          if (cls_q == C_STORE) begin
            pc_en    = 1'b1;
            retire_d = retire_q + 32'd1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == TMO_LAST) begin
          state_d = S_FAULT;
          berr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_wr_en = 1'b1;
        pc_en     = 1'b1;
        retire_d  = retire_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      // Unused encodings collapse into the absorbing fault state
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      cls_q    <= C_ALU;
      wait_q   <= '0;
      retire_q <= '0;
      ill_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      wait_q   <= wait_d;
      retire_q <= retire_d;
      ill_q    <= ill_d;
      berr_q   <= berr_d;
    end
  end

  assign state      = state_q;
  assign illegal    = ill_q;
  assign bus_err    = berr_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Directed bench for mcycle_sequencer: per-class latency, waits,
// timeouts, illegal opcodes, mid-instruction reset and retire wrap.
module tb_mcycle_sequencer;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_en;
  logic        pc_en;
  logic        pc_src;
  logic        reg_wr_en;
  logic [2:0]  state;
  logic        illegal;
  logic        bus_err;
  logic [31:0] retire_cnt;

  int n_vec;
  int n_err;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  mcycle_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .pc_src       (pc_src),
    .reg_wr_en    (reg_wr_en),
    .state        (state),
    .illegal      (illegal),
    .bus_err      (bus_err),
    .retire_cnt   (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled near negedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [6:0] enables();
    return {imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_src, reg_wr_en};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_buserr", 32'(bus_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd1);
  endtask

  // Zero-wait fetch then decode; leaves the DUT in EXEC
  task automatic fetch_decode(input logic [6:0] op);
    opcode     = op;
    imem_ready = 1'b1;
    #1;
    check("f_ir_en", 32'(ir_en), 32'd1);
    cyc();
    imem_ready = 1'b0;
    check("d_state", 32'(state), 32'd1);
    cyc();
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    opcode       = '0;
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
    dmem_ready   = 1'b0;
    @(negedge clk);
    do_reset();

    // R-type: opcode change after decode must not matter
    fetch_decode(OP_R);
    opcode = OP_BAD;
    #1;
    check("r_exec_state", 32'(state), 32'd2);
    check("r_exec_wr", 32'(reg_wr_en), 32'd0);
    cyc();
    check("r_wb_state", 32'(state), 32'd4);
    check("r_wb_en", {25'd0, enables()}, 32'b0000101);
    cyc();
    check("r_retire", retire_cnt, 32'd1);
    check("r_fetch", 32'(state), 32'd0);

    // Load with 3 wait cycles on the data side
    fetch_decode(OP_LD);
    cyc();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      check("ld_mem_state", 32'(state), 32'd3);
      check("ld_mem_en", {25'd0, enables()}, 32'b0100000);
      cyc();
    end
    dmem_ready = 1'b0;
    check("ld_wb_state", 32'(state), 32'd4);
    check("ld_wb_wr", 32'(reg_wr_en), 32'd1);
    cyc();
    check("ld_retire", retire_cnt, 32'd2);

    // Store, zero wait
    fetch_decode(OP_ST);
    cyc();
    dmem_ready = 1'b1;
    #1;
    check("st_mem_en", {25'd0, enables()}, 32'b0110100);
    cyc();
    dmem_ready = 1'b0;
    check("st_fetch", 32'(state), 32'd0);
    check("st_retire", retire_cnt, 32'd3);

    // Branch taken; stray ready outside its own state is ignored
    fetch_decode(OP_BR);
    branch_taken = 1'b1;
    imem_ready   = 1'b1;
    dmem_ready   = 1'b1;
    #1;
    check("br_exec_en", {25'd0, enables()}, 32'b0000110);
    cyc();
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
    dmem_ready   = 1'b0;
    check("br_fetch", 32'(state), 32'd0);
    check("br_retire", retire_cnt, 32'd4);

    // Fetch ready arriving on the 16th (timeout) cycle wins
    for (int i = 0; i < 15; i++) cyc();
    check("tmo_wait_state", 32'(state), 32'd0);
    fetch_decode(OP_LUI);
    check("tmo_no_err", 32'(bus_err), 32'd0);
    check("lui_exec", 32'(state), 32'd2);
    cyc();
    cyc();
    check("lui_retire", retire_cnt, 32'd5);

    // Reset pulsed in the middle of a memory wait
    fetch_decode(OP_LD);
    cyc();
    cyc();
    check("mid_mem_state", 32'(state), 32'd3);
    do_reset();

    // Illegal opcode: absorbing fault, everything quiet
    fetch_decode(OP_BAD);
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    check("ill_state", 32'(state), 32'd5);
    check("ill_flag", 32'(illegal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (i == 19) begin
        check("ill_hold_state", 32'(state), 32'd5);
        check("ill_hold_flag", 32'(illegal), 32'd1);
      end
      check("ill_en", {25'd0, enables()}, 32'd0);
      cyc();
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    do_reset();

    // Fetch timeout: exactly 16 FETCH cycles then fault
    for (int i = 0; i < 16; i++) begin
      check("to_fetch", 32'(state), 32'd0);
      cyc();
    end
    check("to_state", 32'(state), 32'd5);
    check("to_buserr", 32'(bus_err), 32'd1);
    check("to_en", {25'd0, enables()}, 32'd0);
    do_reset();

    // Retire counter wrap
    dut.retire_q = 32'hFFFF_FFFF;
    #1;
    check("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
    fetch_decode(OP_R);
    cyc();
    cyc();
    check("wrap_post", retire_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
